// File: rtl/au_filter_pkg.sv
// Shared constants and scheduler state type for the audio filter chain.
// Defaults describe a 50 MHz system clock producing 40 kHz sample strobes.
package au_filter_pkg;

  typedef enum logic [2:0] {
    RUN,
    FADE_OUT,
    LOAD,
    SETTLE,
    FADE_IN
  } sched_state_t;

  localparam int DIV_DEF       = 1250;
  localparam int GAIN_W_DEF    = 8;
  localparam int GAIN_FS       = (1 << GAIN_W_DEF) - 1;
  localparam int RAMP_STEP_DEF = 16;
  localparam int STABLE_N_DEF  = 4;
  localparam int SETTLE_N_DEF  = 8;

endpackage

// File: rtl/au_sample_div.sv
// Sample-rate divider: a registered one-cycle strobe every DIV clocks,
// first strobe DIV cycles after reset release.
module au_sample_div #(
  parameter int DIV = 1250
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic sample_vld
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt        <= '0;
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= (cnt == LAST);
      cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/au_coe_sched.sv
// Coefficient-switch sequencer: debounces the user select on sample strobes and
// swaps coefficients at a boundary. Define AU_COE_SCHED_FADE_EN for gain fades.
module au_coe_sched
  import au_filter_pkg::*;
#(
  parameter int DIV       = DIV_DEF,
  parameter int CTRL_W    = 3,
  parameter int GAIN_W    = GAIN_W_DEF,
`ifdef AU_COE_SCHED_FADE_EN
  parameter int RAMP_STEP = RAMP_STEP_DEF,
`endif
  parameter int STABLE_N  = STABLE_N_DEF,
  parameter int SETTLE_N  = SETTLE_N_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CTRL_W-1:0] coe_ctrl,
  output logic              sample_vld,
  output logic [CTRL_W-1:0] coe_sel,
  output logic              coe_load,
  output logic [GAIN_W-1:0] gain,
  output logic              busy
);

  localparam logic [GAIN_W-1:0] FS         = '1;
  localparam int                SW         = $clog2(STABLE_N + 1);
  localparam int                TW         = $clog2(SETTLE_N + 1);
  localparam logic [SW-1:0]     STAB_MAX   = SW'(STABLE_N);
  localparam logic [TW-1:0]     SETTLE_MAX = TW'(SETTLE_N);
`ifdef AU_COE_SCHED_FADE_EN
  localparam sched_state_t      RST_STATE  = FADE_IN;
  localparam logic [GAIN_W:0]   STEP       = (GAIN_W + 1)'(RAMP_STEP);
`else
  localparam sched_state_t      RST_STATE  = SETTLE;
`endif

  logic [CTRL_W-1:0] sync_1, sync_q, cand, sel_nxt;
  logic [SW-1:0]     stab_cnt;
  logic [TW-1:0]     settle_cnt, settle_nxt;
  logic              req, load_nxt;
  sched_state_t      state, state_nxt;

  au_sample_div #(.DIV(DIV)) u_div (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .sample_vld(sample_vld)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_1 <= '0;
      sync_q <= '0;
    end else begin
      sync_1 <= coe_ctrl;
      sync_q <= sync_1;
    end
  end

  // A select counts as stable once it has been seen on STABLE_N strobes in a row.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cand     <= '0;
      stab_cnt <= '0;
    end else if (sample_vld) begin
      if (sync_q == cand) begin
        if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 1'b1;
      end else begin
        cand     <= sync_q;
        stab_cnt <= SW'(1);
      end
    end
  end

  assign req  = (stab_cnt == STAB_MAX) && (cand != coe_sel);
  assign busy = (state != RUN);

`ifdef AU_COE_SCHED_FADE_EN
  logic [GAIN_W-1:0] gain_q, gain_nxt, gain_dec, gain_inc;
  logic [GAIN_W:0]   gain_wide_dn, gain_wide_up;

  assign gain_wide_dn = {1'b0, gain_q} - STEP;
  assign gain_wide_up = {1'b0, gain_q} + STEP;
  assign gain_dec     = gain_wide_dn[GAIN_W] ? '0 : gain_wide_dn[GAIN_W-1:0];
  assign gain_inc     = (gain_wide_up > {1'b0, FS}) ? FS : gain_wide_up[GAIN_W-1:0];
  assign gain         = gain_q;
`else
  assign gain = (state == SETTLE) ? '0 : FS;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= RST_STATE;
      settle_cnt <= '0;
      coe_sel    <= '0;
      coe_load   <= 1'b0;
`ifdef AU_COE_SCHED_FADE_EN
      gain_q     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      coe_sel    <= sel_nxt;
      coe_load   <= load_nxt;
`ifdef AU_COE_SCHED_FADE_EN
      gain_q     <= gain_nxt;
`endif
    end
  end

  // Requests are only honoured in RUN and FADE_IN; LOAD takes whatever cand holds then.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    sel_nxt    = coe_sel;
    load_nxt   = 1'b0;
`ifdef AU_COE_SCHED_FADE_EN
    gain_nxt   = gain_q;
`endif
    case (state)
      RUN: begin
`ifdef AU_COE_SCHED_FADE_EN
        gain_nxt = FS;
        if (sample_vld && req) state_nxt = FADE_OUT;
`else
        if (sample_vld && req) state_nxt = LOAD;
`endif
      end
      LOAD: begin
        sel_nxt    = cand;
        load_nxt   = 1'b1;
        settle_nxt = '0;
        state_nxt  = SETTLE;
      end
      SETTLE: begin
`ifdef AU_COE_SCHED_FADE_EN
        gain_nxt = '0;
`endif
        if (sample_vld) begin
          if (settle_cnt + 1'b1 == SETTLE_MAX) begin
`ifdef AU_COE_SCHED_FADE_EN
            state_nxt = FADE_IN;
`else
            state_nxt = RUN;
`endif
          end else begin
            settle_nxt = settle_cnt + 1'b1;
          end
        end
      end
`ifdef AU_COE_SCHED_FADE_EN
      FADE_OUT: begin
        if (gain_q == '0) state_nxt = LOAD;
        else if (sample_vld) gain_nxt = gain_dec;
      end
      FADE_IN: begin
        if (sample_vld && req) begin
          state_nxt = FADE_OUT;
          gain_nxt  = gain_dec;
        end else if (gain_q == FS) begin
          state_nxt = RUN;
        end else if (sample_vld) begin
          gain_nxt = gain_inc;
        end
      end
`endif
      default: state_nxt = RUN;
    endcase
  end

endmodule
